// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: cache request, memory and snoop signals of the arbiter.
interface mem_bus_arbiter_if #(
    parameter int NUMCACHE   = 4,
    parameter int ADDRESSBIT = 32,
    parameter int BLOCKWIDTH = 128
);
    logic [NUMCACHE-1:0]            req;
    logic [NUMCACHE-1:0]            reqRW;
    logic [NUMCACHE*ADDRESSBIT-1:0] reqAddr;
    logic [NUMCACHE*BLOCKWIDTH-1:0] reqData;
    logic [NUMCACHE-1:0]            grant;
    logic [NUMCACHE-1:0]            ack;
    logic                           err;
    logic [BLOCKWIDTH-1:0]          rdData;
    logic                           memReq;
    logic                           memRW;
    logic [ADDRESSBIT-1:0]          memAddr;
    logic [BLOCKWIDTH-1:0]          memDataOut;
    logic [BLOCKWIDTH-1:0]          memDataIn;
    logic                           memSuccess;
    logic                           snoopValid;
    logic                           snoopRW;
    logic [ADDRESSBIT-1:0]          snoopAddr;
    logic [NUMCACHE-1:0]            snoopSrc;
    logic                           busy;

    modport master (
        input  req, reqRW, reqAddr, reqData, memDataIn, memSuccess,
        output grant, ack, err, rdData, memReq, memRW, memAddr, memDataOut,
               snoopValid, snoopRW, snoopAddr, snoopSrc, busy
    );
    modport slave (
        output req, reqRW, reqAddr, reqData, memDataIn, memSuccess,
        input  grant, ack, err, rdData, memReq, memRW, memAddr, memDataOut,
               snoopValid, snoopRW, snoopAddr, snoopSrc, busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter sharing one memory port among caches, with snoop broadcast and timeout.
module mem_bus_arbiter #(
    parameter int NUMCACHE   = 4,
    parameter int ADDRESSBIT = 32,
    parameter int WORDSIZE   = 32,
    parameter int BLOCKBYTE  = 4,
    parameter int BLOCKWIDTH = WORDSIZE * BLOCKBYTE,
    parameter int TIMEOUT    = 255
) (
    input logic clk,
    input logic rst_n,
    mem_bus_arbiter_if.master bus
);
    localparam int IW = NUMCACHE > 1 ? $clog2(NUMCACHE) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, MEM, DONE} stateT;

    stateT                 state, stateNext;
    logic [IW-1:0]         ptr, winner, winNext;
    logic [NUMCACHE-1:0]   grantReg;
    logic                  latRW, errFlag, expired;
    logic [ADDRESSBIT-1:0] latAddr;
    logic [BLOCKWIDTH-1:0] latData, rdReg;
    logic [7:0]            cnt;

    assign expired = cnt == 8'(TIMEOUT - 1);

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        winNext = ptr;
        for (int i = NUMCACHE; i >= 1; i--) begin
            int idx;
            idx = (int'(ptr) + i) % NUMCACHE;
            if (bus.req[idx]) winNext = IW'(idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    stateNext = |bus.req ? GRANT : IDLE;
            GRANT:   stateNext = MEM;
            MEM:     stateNext = (bus.memSuccess || expired) ? DONE : MEM;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= IW'(NUMCACHE - 1);
            winner   <= '0;
            grantReg <= '0;
            latRW    <= 1'b0;
            latAddr  <= '0;
            latData  <= '0;
            rdReg    <= '0;
            errFlag  <= 1'b0;
            cnt      <= '0;
        end else begin
            if (state == IDLE && |bus.req) begin
                grantReg <= NUMCACHE'(1) << winNext;
                winner   <= winNext;
                latRW    <= bus.reqRW[winNext];
                latAddr  <= bus.reqAddr[winNext*ADDRESSBIT +: ADDRESSBIT];
                latData  <= bus.reqData[winNext*BLOCKWIDTH +: BLOCKWIDTH];
                errFlag  <= 1'b0;
                cnt      <= '0;
            end
            if (state == MEM) begin
                cnt <= cnt + 8'd1;
                if (bus.memSuccess && !latRW) rdReg <= bus.memDataIn;
                if (!bus.memSuccess && expired) errFlag <= 1'b1;
            end
            if (state == DONE) begin
                grantReg <= '0;
                ptr      <= winner;
            end
        end
    end

    assign bus.grant      = grantReg;
    assign bus.ack        = state == DONE ? grantReg : '0;
    assign bus.err        = state == DONE && errFlag;
    assign bus.rdData     = rdReg;
    assign bus.memReq     = state == MEM;
    assign bus.memRW      = latRW;
    assign bus.memAddr    = latAddr;
    assign bus.memDataOut = latData;
    assign bus.snoopValid = state == GRANT;
    assign bus.snoopRW    = latRW;
    assign bus.snoopAddr  = latAddr;
    assign bus.snoopSrc   = state == GRANT ? grantReg : '0;
    assign bus.busy       = state != IDLE;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: random and directed transactions checked against a transaction-level round-robin model.
module tb_mem_bus_arbiter;
    localparam int NC = 4, AB = 32, BW = 128, TO = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int nCmp = 0, nErr = 0, snoopCnt = 0, ptrM = NC - 1;
    logic pend[NC];
    logic pRW[NC];
    logic [AB-1:0] pAddr[NC];
    logic [BW-1:0] pData[NC];
    int waits[NC];
    logic [BW-1:0] rdM;

    mem_bus_arbiter_if #(.NUMCACHE(NC), .ADDRESSBIT(AB), .BLOCKWIDTH(BW)) bus ();

    mem_bus_arbiter #(
        .NUMCACHE(NC), .ADDRESSBIT(AB), .WORDSIZE(32), .BLOCKBYTE(4),
        .BLOCKWIDTH(BW), .TIMEOUT(TO)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.snoopValid) snoopCnt++;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        nCmp++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic newReq(input int i, input logic rw, input logic [AB-1:0] a, input logic [BW-1:0] d);
        pend[i] = 1'b1;
        pRW[i] = rw;
        pAddr[i] = a;
        pData[i] = d;
    endtask

    task automatic newRand(input int i);
        newReq(i, 1'($urandom_range(0, 1)), $urandom, rnd());
    endtask

    task automatic drive;
        for (int i = 0; i < NC; i++) begin
            bus.req[i] = pend[i];
            bus.reqRW[i] = pRW[i];
            bus.reqAddr[i*AB +: AB] = pAddr[i];
            bus.reqData[i*BW +: BW] = pData[i];
        end
    endtask

    task automatic resetModel;
        ptrM = NC - 1;
        rdM = '0;
        for (int i = 0; i < NC; i++) begin
            pend[i] = 1'b0;
            pRW[i] = 1'b0;
            pAddr[i] = '0;
            pData[i] = '0;
            waits[i] = 0;
        end
    endtask

    // One full transaction starting from an IDLE cycle; w returns the served cache.
    task automatic txn(input int delay, input bit toCase, input bit noise, input logic [BW-1:0] md, output int w);
        logic rw;
        logic [AB-1:0] a;
        logic [BW-1:0] d, g;
        logic snap[NC];
        w = -1;
        for (int k = 1; k <= NC; k++) begin
            int j;
            j = (ptrM + k) % NC;
            if (w < 0 && pend[j]) w = j;
        end
        if (w < 0) w = 0;
        snap = pend;
        rw = pRW[w];
        a = pAddr[w];
        d = pData[w];
        g = BW'(1) << w;
        drive();
        tick();
        check("grant", BW'(bus.grant), g);
        check("snoopValid", BW'(bus.snoopValid), BW'(1));
        check("snoopSrc", BW'(bus.snoopSrc), g);
        check("snoopAddr", BW'(bus.snoopAddr), BW'(a));
        check("snoopRW", BW'(bus.snoopRW), BW'(rw));
        check("memReq_grant", BW'(bus.memReq), BW'(0));
        if (noise) begin
            bus.memSuccess = 1'($urandom_range(0, 1));
            for (int i = 0; i < NC; i++) if (!pend[i] && $urandom_range(0, 2) == 0) newRand(i);
            drive();
        end
        tick();
        bus.memSuccess = 1'b0;
        check("memReq", BW'(bus.memReq), BW'(1));
        check("memAddr", BW'(bus.memAddr), BW'(a));
        check("memRW", BW'(bus.memRW), BW'(rw));
        check("memDataOut", bus.memDataOut, d);
        check("snoop_once", BW'(bus.snoopValid), BW'(0));
        if (toCase) begin
            for (int c = 1; c < TO; c++) begin
                bus.memDataIn = rnd();
                tick();
            end
            check("to_still_mem", BW'(bus.memReq), BW'(1));
            check("to_no_early_ack", BW'(bus.ack), BW'(0));
            tick();
        end else begin
            for (int c = 0; c < delay; c++) begin
                tick();
                check("mem_hold", BW'({bus.memReq, bus.memRW}), BW'({1'b1, rw}));
                check("mem_data_hold", bus.memDataOut, d);
            end
            bus.memDataIn = md;
            bus.memSuccess = 1'b1;
            tick();
            bus.memSuccess = 1'b0;
            if (!rw) rdM = md;
        end
        check("ack", BW'(bus.ack), g);
        check("err", BW'(bus.err), BW'(toCase));
        check("rdData", bus.rdData, rdM);
        check("memReq_done", BW'(bus.memReq), BW'(0));
        check("fair_wait", BW'(waits[w] < NC), BW'(1));
        for (int i = 0; i < NC; i++) if (i != w && snap[i]) waits[i]++;
        waits[w] = 0;
        ptrM = w;
        if (noise && $urandom_range(0, 3) == 0) newRand(w);
        else pend[w] = 1'b0;
        drive();
        tick();
        check("idle_busy", BW'(bus.busy), BW'(0));
        check("idle_ack", BW'({bus.ack, bus.err}), BW'(0));
        check("idle_grant", BW'(bus.grant), BW'(0));
    endtask

    initial begin
        int w, sc;
        bit any;
        bus.memSuccess = 1'b0;
        bus.memDataIn = '0;
        resetModel();
        drive();
        #12;
        check("rst_grant", BW'(bus.grant), BW'(0));
        check("rst_busy", BW'({bus.busy, bus.memReq, bus.snoopValid, bus.ack}), BW'(0));
        check("rst_rdData", bus.rdData, BW'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NC; i++) newReq(i, 1'b0, AB'(i * 64), rnd());
        sc = snoopCnt;
        for (int k = 0; k < NC; k++) begin
            txn(1, 1'b0, 1'b0, rnd(), w);
            check("rr_order", BW'(w), BW'(k));
        end
        check("snoop_pulses", BW'(snoopCnt - sc), BW'(4));

        newReq(0, 1'b0, 32'h40, rnd());
        txn(3, 1'b0, 1'b0, {16{8'hA5}}, w);
        check("read_src", BW'(w), BW'(0));
        check("read_data", bus.rdData, {16{8'hA5}});

        newReq(2, 1'b1, 32'h80, BW'(16'h1234));
        txn(4, 1'b0, 1'b0, rnd(), w);
        check("write_src", BW'(w), BW'(2));
        check("write_rd_kept", bus.rdData, {16{8'hA5}});

        newReq(1, 1'b0, 32'hC0, rnd());
        txn(0, 1'b1, 1'b0, rnd(), w);

        bus.memSuccess = 1'b1;
        tick();
        bus.memSuccess = 1'b0;
        check("spurious_idle", BW'({bus.busy, bus.ack}), BW'(0));

        for (int n = 0; n < 40; n++) begin
            any = 1'b0;
            for (int i = 0; i < NC; i++) if (!pend[i] && $urandom_range(0, 1) == 1) newRand(i);
            for (int i = 0; i < NC; i++) any |= pend[i];
            if (!any) newRand(int'($urandom_range(0, NC - 1)));
            txn(int'($urandom_range(0, 6)), n == 20, 1'b1, rnd(), w);
        end

        for (int i = 0; i < NC; i++) pend[i] = 1'b0;
        newReq(1, 1'b0, 32'h100, rnd());
        drive();
        tick();
        tick();
        check("pre_rst_memReq", BW'(bus.memReq), BW'(1));
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_memReq", BW'(bus.memReq), BW'(0));
        check("rst_mid_grant", BW'(bus.grant), BW'(0));
        check("rst_mid_rdData", bus.rdData, BW'(0));
        resetModel();
        drive();
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst_no_ack", BW'({bus.ack, bus.err}), BW'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        newReq(0, 1'b0, 32'h200, rnd());
        newReq(2, 1'b1, 32'h300, rnd());
        txn(2, 1'b0, 1'b0, rnd(), w);
        check("post_rst_first", BW'(w), BW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NUMCACHE, 4, number of requesting caches.
  ADDRESSBIT, 32, address width.
  BLOCKWIDTH, WORDSIZE*BLOCKBYTE, one cache line in bits.
  TIMEOUT, 255, maximum MEM-state cycles before abort.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock, rising edge.
  rst_n  in  1  asynchronous, active-low reset.
  req  in  NUMCACHE  per-cache request level.
  reqRW  in  NUMCACHE  per-cache direction; 1=write, 0=read.
  reqAddr  in  NUMCACHE*ADDRESSBIT  flattened block addresses; cache i at slice i.
  reqData  in  NUMCACHE*BLOCKWIDTH  flattened write lines.
  grant  out  NUMCACHE  one-hot owner level.
  ack  out  NUMCACHE  one-hot one-cycle completion pulse.
  err  out  1  one-cycle timeout pulse, coincident with ack.
  rdData  out  BLOCKWIDTH  line returned by the last read.
  memReq  out  1  memory request level.
  memRW  out  1  memory direction.
  memAddr  out  ADDRESSBIT  memory address.
  memDataOut  out  BLOCKWIDTH  write line to memory.
  memDataIn  in  BLOCKWIDTH  read line from memory.
  memSuccess  in  1  memory completion pulse.
  snoopValid  out  1  one-cycle bus broadcast.
  snoopRW  out  1  direction of the broadcast transaction.
  snoopAddr  out  ADDRESSBIT  address of the broadcast transaction.
  snoopSrc  out  NUMCACHE  one-hot originator; non-originators act on the broadcast.
  busy  out  1  high in every state except IDLE.

Function
REQ-003 FSM states SHALL be IDLE, GRANT, MEM, DONE; all transitions occur on the rising clk edge.
REQ-004 IDLE SHALL sample req; if any bit is set, it SHALL select a winner round-robin, searching from ptr+1 upward modulo NUMCACHE.
REQ-005 On selection, the FSM SHALL latch the winner's reqRW, reqAddr and reqData, set grant one-hot, and go to GRANT.
REQ-006 In IDLE with req=0, the FSM SHALL remain in IDLE.
REQ-007 GRANT SHALL last exactly one cycle and drive snoopValid=1, with snoopRW, snoopAddr and snoopSrc taken from the latched request; the FSM then goes to MEM.
REQ-008 MEM SHALL hold memReq=1 and keep memRW, memAddr and memDataOut stable from the latch until exit.
REQ-009 In MEM, memSuccess=1 SHALL move the FSM to DONE.
REQ-010 If the latched transaction is a read, memDataIn SHALL be captured into rdData on the same edge that leaves MEM.
REQ-011 On writes, rdData SHALL hold its previous value.
REQ-012 In MEM, a 8-bit counter SHALL count cycles; at TIMEOUT cycles without memSuccess, the FSM SHALL go to DONE with the err flag set and rdData unchanged.
REQ-013 DONE SHALL last one cycle and pulse ack[winner]=1 (and err when the err flag is set).
REQ-014 DONE SHALL set ptr=winner, clear grant and memReq, and return to IDLE.
REQ-015 Latency: with req seen in IDLE at cycle t, grant SHALL rise at t+1, snoopValid SHALL pulse at t+1, and memReq SHALL rise at t+2.
REQ-016 Latency: with memSuccess seen at cycle m, ack SHALL pulse at m+1.
REQ-017 memSuccess outside MEM SHALL be ignored.
REQ-018 req changes after the latch SHALL be ignored; a transaction, once granted, always completes.
REQ-019 Requesters SHALL hold req until ack.
REQ-020 A req still high in the cycle after ack SHALL be re-arbitrated normally.
REQ-021 Simultaneous requests SHALL be served one per transaction in round-robin order; no requester waits more than NUMCACHE-1 transactions.
REQ-022 At most one bit of grant, ack or snoopSrc SHALL be set in any cycle.

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE, ptr=NUMCACHE-1, and all counters and latches to 0.
REQ-024 rst_n=0 SHALL immediately force every output to 0, including rdData.
REQ-025 Reset mid-transaction SHALL abort the transaction with no ack and no err.
REQ-026 The first request after reset release SHALL be sampled on the first rising edge with rst_n=1.

Verification
REQ-027 Single read: req=0001, reqRW[0]=0, addr 0x40, memSuccess 3 cycles after memReq with memDataIn=0xA5.. -> snoopValid 1 cycle with snoopSrc=0001, ack=0001 pulse, rdData=0xA5...
REQ-028 All four requests at once, after reset -> ack order 0001, 0010, 0100, 1000; exactly four snoop pulses.
REQ-029 Write from cache 2 with data 0x1234 -> memRW=1 and memDataOut=0x1234 throughout MEM; rdData unchanged.
REQ-030 memSuccess never asserted -> ack and err pulse exactly 255 cycles after memReq rose; FSM returns to IDLE.
REQ-031 rst_n pulsed low during MEM -> memReq and grant drop within the same cycle, with no ack; a subsequent request from cache 0 wins first.
REQ-032 Spurious memSuccess in IDLE and GRANT -> no state change and no ack.
